// File: rtl/td4_pkg.sv
// Shared TD4 definitions: mnemonic indices, opcode constants and encoding helpers.
// Imported by the loader, the instruction decoder and assembler-side models.
package td4_pkg;

    localparam int unsigned TD4_ADDR_W = 4;
    localparam int unsigned TD4_WORD_W = 8;

    typedef enum logic [3:0] {
        MN_ADD_A_IM = 4'd0,
        MN_MOV_A_B  = 4'd1,
        MN_IN_A     = 4'd2,
        MN_MOV_A_IM = 4'd3,
        MN_MOV_B_A  = 4'd4,
        MN_ADD_B_IM = 4'd5,
        MN_IN_B     = 4'd6,
        MN_MOV_B_IM = 4'd7,
        MN_OUT_B    = 4'd8,
        MN_OUT_IM   = 4'd9,
        MN_JNC_IM   = 4'd10,
        MN_JMP_IM   = 4'd11
    } td4_mn_t;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC_IM   = 4'b1110;
    localparam logic [3:0] OP_JMP_IM   = 4'b1111;

    typedef struct packed {
        logic                  legal;
        logic [TD4_WORD_W-1:0] word;
    } td4_enc_t;

    // Register-only forms carry no immediate; their im field is forced to zero.
    function automatic logic td4_has_imm(input logic [3:0] mn);
        case (mn)
            MN_MOV_A_B, MN_IN_A, MN_MOV_B_A, MN_IN_B, MN_OUT_B: return 1'b0;
            default:                                            return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/td4_prog_loader_if.sv
// Symbolic instruction stream into the program loader: start pulse plus
// valid/ready beats of mnemonic, immediate and last flag.
interface td4_prog_loader_if;

    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_mn;
    logic [3:0] in_im;
    logic       in_last;

    modport master (
        output start, in_valid, in_mn, in_im, in_last,
        input  in_ready
    );

    modport slave (
        input  start, in_valid, in_mn, in_im, in_last,
        output in_ready
    );

endinterface

// File: rtl/td4_insn_encoder.sv
// Combinational mnemonic/immediate to TD4 word encoder with legality flag.
module td4_insn_encoder
    import td4_pkg::*;
(
    input  logic [3:0] mn,
    input  logic [3:0] im,
    output td4_enc_t   enc
);

    logic [3:0] op;
    logic       legal;

    always_comb begin
        op    = '0;
        legal = 1'b1;
        case (mn)
            MN_ADD_A_IM: op = OP_ADD_A_IM;
            MN_MOV_A_B:  op = OP_MOV_A_B;
            MN_IN_A:     op = OP_IN_A;
            MN_MOV_A_IM: op = OP_MOV_A_IM;
            MN_MOV_B_A:  op = OP_MOV_B_A;
            MN_ADD_B_IM: op = OP_ADD_B_IM;
            MN_IN_B:     op = OP_IN_B;
            MN_MOV_B_IM: op = OP_MOV_B_IM;
            MN_OUT_B:    op = OP_OUT_B;
            MN_OUT_IM:   op = OP_OUT_IM;
            MN_JNC_IM:   op = OP_JNC_IM;
            MN_JMP_IM:   op = OP_JMP_IM;
            default:     legal = 1'b0;
        endcase
        enc.legal = legal;
        enc.word  = {op, td4_has_imm(mn) ? im : 4'b0000};
    end

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program loader: encodes a symbolic instruction stream into program memory,
// pads the remainder with zero words and holds the CPU in reset until complete.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    td4_prog_loader_if.slave      ins,
    output logic                  wr_en,
    output logic [TD4_ADDR_W-1:0] wr_addr,
    output logic [TD4_WORD_W-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [4:0]            count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [TD4_ADDR_W-1:0] LAST_ADDR = TD4_ADDR_W'(DEPTH - 1);

    state_t                state;
    logic [TD4_ADDR_W-1:0] addr;
    logic                  ready_q;
    td4_enc_t              enc;
    logic                  accept;
    logic                  end_beat;
    logic                  restart;

    td4_insn_encoder u_enc (
        .mn  (ins.in_mn),
        .im  (ins.in_im),
        .enc (enc)
    );

    assign ins.in_ready = ready_q;
    assign accept       = ins.in_valid & ready_q;
    assign end_beat     = ins.in_last | (addr == LAST_ADDR);
    // start only takes effect from the resting states; LOAD and FILL ignore it.
    assign restart      = ins.start &
                          ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            ready_q  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                state    <= ST_LOAD;
                addr     <= '0;
                count    <= '0;
                err      <= 1'b0;
                done     <= 1'b0;
                cpu_hold <= 1'b1;
                ready_q  <= 1'b1;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (accept) begin
                            if (enc.legal) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= enc.word;
                                addr    <= addr + 1'b1;
                                count   <= count + 1'b1;
                                if (end_beat) begin
                                    ready_q <= 1'b0;
                                    state   <= (addr == LAST_ADDR) ? ST_DONE : ST_FILL;
                                end
                            end else begin
                                err     <= 1'b1;
                                ready_q <= 1'b0;
                                state   <= ST_ERR;
                            end
                        end
                    end
                    ST_FILL: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= '0;
                        addr    <= addr + 1'b1;
                        if (addr == LAST_ADDR) begin
                            state <= ST_DONE;
                        end
                    end
                    // done/cpu_hold follow one cycle after entry, after the final write is visible.
                    ST_DONE: begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: transaction-schedule model checked every cycle,
// plus literal expectations on memory image, counts and latencies.
module tb_td4_prog_loader;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [4:0] count;

    td4_prog_loader_if ins ();

    td4_prog_loader #(.DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .ins      (ins),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    // Model: expected writes scheduled by absolute cycle, plus status.
    wr_t m_q[$];
    bit  m_armed   = 0;
    bit  m_loading = 0;
    bit  m_err     = 0;
    int  m_count   = 0;
    int  m_addr    = 0;
    int  m_done_at = -1;

    int  mem_seen [16];
    int  nwrites = 0;

    function automatic int encode(input int mn, input int im);
        int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 14, 15};
        bit regonly;
        regonly = (mn == 1) || (mn == 2) || (mn == 4) || (mn == 6) || (mn == 8);
        return ops[mn] * 16 + (regonly ? 0 : im);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int  n;
        wr_t w;
        if (m_q.size() > 0 && m_q[0].cyc == cyc) void'(m_q.pop_front());
        cyc++;
        n = cyc - 1;
        if (reset) begin
            m_q.delete();
            m_armed   = 1;
            m_loading = 0;
            m_err     = 0;
            m_count   = 0;
            m_addr    = 0;
            m_done_at = -1;
        end else if (ins.start &&
                     !(m_loading || (m_done_at >= 0 && n + 1 < m_done_at))) begin
            m_loading = 1;
            m_err     = 0;
            m_count   = 0;
            m_addr    = 0;
            m_done_at = -1;
        end else if (m_loading && ins.in_valid) begin
            if (int'(ins.in_mn) < 12) begin
                w.cyc  = n + 1;
                w.addr = m_addr;
                w.data = encode(int'(ins.in_mn), int'(ins.in_im));
                m_q.push_back(w);
                m_count++;
                if (ins.in_last || m_addr == 15) begin
                    m_loading = 0;
                    if (m_addr == 15) begin
                        m_done_at = n + 2;
                    end else begin
                        for (int j = m_addr + 1; j <= 15; j++) begin
                            w.cyc  = n + 1 + j - m_addr;
                            w.addr = j;
                            w.data = 0;
                            m_q.push_back(w);
                        end
                        m_done_at = n + 17 - m_addr;
                    end
                end
                m_addr++;
            end else begin
                m_err     = 1;
                m_loading = 0;
            end
        end
    endtask

    task automatic compare();
        bit exp_we;
        bit exp_done;
        if (wr_en === 1'b1) begin
            mem_seen[wr_addr] = int'(wr_data);
            nwrites++;
        end
        if (!m_armed) return;
        exp_we   = (m_q.size() > 0) && (m_q[0].cyc == cyc);
        exp_done = (m_done_at >= 0) && (cyc >= m_done_at);
        check("wr_en", wr_en, exp_we);
        if (exp_we) begin
            check("wr_addr", wr_addr, m_q[0].addr);
            check("wr_data", wr_data, m_q[0].data);
        end
        check("in_ready", ins.in_ready, m_loading);
        check("done", done, exp_done);
        check("cpu_hold", cpu_hold, !exp_done);
        check("err", err, m_err);
        check("count", count, m_count);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_start();
        ins.start = 1'b1;
        step();
        ins.start = 1'b0;
    endtask

    // Leaves in_valid high so consecutive calls form back-to-back beats.
    task automatic send_beat(input int mn, input int im, input bit last);
        bit acc;
        acc          = 1'b0;
        ins.in_valid = 1'b1;
        ins.in_mn    = 4'(mn);
        ins.in_im    = 4'(im);
        ins.in_last  = last;
        for (int t = 0; t < 40; t++) begin
            acc = ins.in_ready;
            step();
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout actual=no_ready required=ready (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int i;
        i = 0;
        while (done !== 1'b1 && i < 60) begin
            step();
            i++;
        end
        check(name, i, exp_cycles);
    endtask

    initial begin
        int base;
        reset        = 1'b1;
        ins.start    = 1'b0;
        ins.in_valid = 1'b0;
        ins.in_mn    = '0;
        ins.in_im    = '0;
        ins.in_last  = 1'b0;
        for (int i = 0; i < 16; i++) mem_seen[i] = -1;

        step();
        step();
        reset = 1'b0;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_in_ready", ins.in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        step();

        // Short program with padding.
        base = nwrites;
        do_start();
        send_beat(3, 3, 0);
        send_beat(0, 1, 0);
        send_beat(11, 0, 1);
        ins.in_valid = 1'b0;
        wait_done("t1_done_latency", 14);
        check("t1_mem0", mem_seen[0], 32'h33);
        check("t1_mem1", mem_seen[1], 32'h01);
        check("t1_mem2", mem_seen[2], 32'hF0);
        for (int a = 3; a < 16; a++) check("t1_pad", mem_seen[a], 0);
        check("t1_writes", nwrites - base, 16);
        check("t1_count", count, 3);
        check("t1_cpu_hold", cpu_hold, 0);
        step();

        // Full 16-beat program, no in_last.
        base = nwrites;
        do_start();
        for (int i = 0; i < 16; i++) send_beat(9, i, 0);
        ins.in_im = 4'h0;
        check("t2_no_17th_ready", ins.in_ready, 0);
        wait_done("t2_done_latency", 1);
        for (int k = 0; k < 3; k++) begin
            check("t2_no_17th_ready_hold", ins.in_ready, 0);
            step();
        end
        ins.in_valid = 1'b0;
        for (int a = 0; a < 16; a++) check("t2_mem", mem_seen[a], 32'hB0 + a);
        check("t2_writes", nwrites - base, 16);
        check("t2_count", count, 16);
        step();

        // Register-only forms drop the immediate.
        do_start();
        send_beat(1, 7, 0);
        send_beat(8, 15, 1);
        ins.in_valid = 1'b0;
        wait_done("t3_done_latency", 15);
        check("t3_mem0", mem_seen[0], 32'h10);
        check("t3_mem1", mem_seen[1], 32'h90);

        // Illegal mnemonic then recovery.
        base = nwrites;
        do_start();
        send_beat(3, 5, 0);
        send_beat(13, 2, 0);
        ins.in_valid = 1'b0;
        step();
        step();
        check("t4_err", err, 1);
        check("t4_count", count, 1);
        check("t4_cpu_hold", cpu_hold, 1);
        check("t4_in_ready", ins.in_ready, 0);
        check("t4_writes", nwrites - base, 1);
        check("t4_mem0", mem_seen[0], 32'h35);
        do_start();
        check("t4_err_cleared", err, 0);
        send_beat(7, 3, 1);
        ins.in_valid = 1'b0;
        wait_done("t4_reload_latency", 16);
        check("t4_reload_mem0", mem_seen[0], 32'h73);
        step();

        // Gapped valid, ignored start in LOAD and FILL, reset during FILL.
        do_start();
        send_beat(3, 1, 0);
        ins.in_valid = 1'b0;
        step();
        send_beat(5, 2, 0);
        ins.in_valid = 1'b0;
        ins.start    = 1'b1;
        step();
        ins.start    = 1'b0;
        step();
        send_beat(10, 4, 1);
        ins.in_valid = 1'b0;
        step();
        step();
        step();
        check("t5_mem0", mem_seen[0], 32'h31);
        check("t5_mem1", mem_seen[1], 32'h52);
        check("t5_mem2", mem_seen[2], 32'hE4);
        ins.start = 1'b1;
        step();
        ins.start = 1'b0;
        reset     = 1'b1;
        step();
        check("t5_rst_wr_en", wr_en, 0);
        check("t5_rst_cpu_hold", cpu_hold, 1);
        check("t5_rst_done", done, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("t5_idle_ready", ins.in_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/td4_prog_loader.md
# td4_prog_loader

Program loader for the TD4 CPU: the writer side of the instruction path that the TD4 instruction decoder reads. It accepts a stream of symbolic instructions (mnemonic index plus 4-bit immediate) over a valid/ready handshake and encodes each into the 8-bit TD4 word `{op[3:0], im[3:0]}`. It writes the words sequentially into the 16-entry program memory, pads unused entries, and holds the CPU in reset until the image is complete.

## Interface
- `DEPTH`, default 16: program memory entries; fixed by the 4-bit TD4 address space.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a load.
- `in_valid` in 1: instruction beat valid.
- `in_ready` out 1: loader accepts a beat this cycle.
- `in_mn` in 4: mnemonic index (see Operation).
- `in_im` in 4: immediate.
- `in_last` in 1: final beat of the program.
- `wr_en` out 1: program-memory write strobe.
- `wr_addr` out 4: write address.
- `wr_data` out 8: encoded word, `{op, im}`.
- `cpu_hold` out 1: keeps the CPU in reset while high.
- `done` out 1: image complete; level signal.
- `err` out 1: sticky illegal-mnemonic flag.
- `count` out 5: number of stream beats written (0..16; excludes pad words).

## Operation
- Encoding, mnemonic to op:
  - 0 ADD A,Im → 0000
  - 1 MOV A,B → 0001
  - 2 IN A → 0010
  - 3 MOV A,Im → 0011
  - 4 MOV B,A → 0100
  - 5 ADD B,Im → 0101
  - 6 IN B → 0110
  - 7 MOV B,Im → 0111
  - 8 OUT B → 1001
  - 9 OUT Im → 1011
  - 10 JNC Im → 1110
  - 11 JMP Im → 1111
- Register-only forms (1, 2, 4, 6, 8) write im = 0000 regardless of `in_im`.
- Mnemonics 12..15 are illegal.
- FSM states: IDLE, LOAD, FILL, DONE, ERR.
  - IDLE: `cpu_hold`=1, `in_ready`=0. `start` → LOAD; clears `addr`, `count`, `err`.
  - LOAD: `in_ready`=1, `cpu_hold`=1. A beat is accepted on `in_valid & in_ready`.
    - Legal beat: write at `addr`, then `addr`++ and `count`++.
    - Legal beat that is last (`in_last`=1 or `addr`=15): `addr`=15 → DONE; otherwise → FILL.
    - Illegal beat: no write, `err`=1, → ERR.
  - FILL: one pad write of 8'h00 per cycle at `addr`..15, no handshake. → DONE after the write to address 15.
  - DONE: `done`=1, `cpu_hold`=0, `in_ready`=0. `start` → LOAD.
  - ERR: `cpu_hold`=1, `in_ready`=0, `err`=1. `start` → LOAD, which clears `err`.
- `start` in LOAD or FILL is ignored.
- A 17th beat is never accepted, because `in_ready` drops after address 15 is written.

## Timing
- Reset values: `cpu_hold`=1; `in_ready`, `wr_en`, `done`, `err`=0; `wr_addr`, `wr_data`, `count`=0; state IDLE.
- `in_ready` is a registered state decode. It is high the cycle after `start` is sampled.
- Write latency is 1 cycle: a beat accepted in cycle N gives `wr_en`=1 with `wr_addr`/`wr_data` in cycle N+1. `wr_en` is a single-cycle pulse per word.
- Back-to-back beats with `in_valid` held high give one write per cycle. Gaps in `in_valid` give gaps in `wr_en`; no other effect.
- Last beat at address k<15 accepted in cycle N:
  - Write k appears in N+1.
  - Pad writes k+1..15 appear in N+2..N+16-k.
  - `done` rises and `cpu_hold` falls in N+17-k.
- Last write at address 15 in cycle M: `done`=1 and `cpu_hold`=0 from M+1.
- Illegal beat accepted in cycle N: `err`=1 in N+1, `wr_en`=0 in N+1, `in_ready`=0 from N+1.
- `reset` mid-operation: all outputs take reset values on the next cycle, and no further `wr_en`. Memory contents are undefined, and `cpu_hold`=1 guards them.

## Structure
- Shared package `td4_pkg`:
  - mnemonic enum `td4_mn_t` (values 0..11)
  - 4-bit opcode constants
  - `TD4_ADDR_W`=4
  - `TD4_WORD_W`=8
  - `td4_has_imm` predicate

  The decoder and any assembler/bench model import the same opcode constants.
- Natural sub-module: `td4_insn_encoder`, a combinational mnemonic/imm → `{legal, word}` function. The FSM, address counter and output registers stay in the top level.

## Test plan
- Reset: assert `reset` 2 cycles → `cpu_hold`=1, `in_ready`=0, `wr_en`=0, `done`=0, `err`=0, `count`=0.
- `start`, then beats (3,3), (0,1), (11,0,last) → writes 0:0x33, 1:0x01, 2:0xF0; pads 3..15 with 0x00 on consecutive cycles; `done`=1, `cpu_hold`=0, `count`=3.
- 16 legal beats, no `in_last` (e.g. (9,i) for i=0..15) → writes 0xB0..0xBF at 0..15; no pad writes; 17th `in_valid` sees `in_ready`=0; `count`=16.
- Register forms: (1,7), (8,F) → `wr_data` 0x10 and 0x90 (im forced to 0).
- Illegal: beats (3,5), (13,2) → one write 0:0x35, then `err`=1, no write for the second beat, `count`=1, `cpu_hold`=1. A subsequent `start` clears `err` and reloads from address 0.
- Robustness: `in_valid` toggling every other cycle gives writes only on accepted beats. `start` pulsed mid-LOAD is ignored. `reset` during FILL gives `wr_en`=0 next cycle and `cpu_hold`=1.
